// File: rtl/score_bcd_tracker.sv
// Captures the final game score on each rising game_end, converts it to packed BCD with a
// one-bit-per-clock double-dabble, and tracks the session high score for the digit driver.
//
// state | meaning
// IDLE  | waiting for a game_end rising edge
// CONV  | shifting one score bit per clock into the BCD register
module score_bcd_tracker #(
   parameter int SCORE_W    = 8,
   parameter int BCD_DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SCORE_W-1:0]      score,
   input  logic                    game_end,
   input  logic                    best_clr,
   output logic                    busy,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] cur_bcd,
   output logic [4*BCD_DIGITS-1:0] best_bcd,
   output logic                    new_best,
   output logic                    overrun
);

   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCORE_W - 1);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               game_end_d;
   logic [SCORE_W-1:0] cap_q;
   logic [SCORE_W-1:0] sh_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [SCORE_W-1:0] pend_val_q;
   logic               pend_full_q;
   logic [SCORE_W-1:0] best_bin_q;

   logic               ge_rise;
   logic               last_bit;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_nx;
   logic [SCORE_W-1:0] sh_nx;

   always_comb begin
      ge_rise  = game_end & ~game_end_d;
      last_bit = (state_q == CONV) && (bit_cnt_q == LAST_BIT);

      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      {bcd_nx, sh_nx} = {bcd_adj, sh_q} << 1;

      state_d = state_q;
      if (state_q == IDLE) begin
         if (ge_rise) begin
            state_d = CONV;
         end
      end else begin
         // A rise on the completion cycle chains straight into the next conversion.
         if (last_bit && !pend_full_q && !ge_rise) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         game_end_d  <= 1'b1;
         cap_q       <= '0;
         sh_q        <= '0;
         bcd_q       <= '0;
         bit_cnt_q   <= '0;
         pend_val_q  <= '0;
         pend_full_q <= 1'b0;
         best_bin_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cur_bcd     <= '0;
         best_bcd    <= '0;
         new_best    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy       <= (state_d == CONV);
         game_end_d <= game_end;
         done       <= 1'b0;

         if (state_q == IDLE) begin
            if (ge_rise) begin
               cap_q     <= score;
               sh_q      <= score;
               bcd_q     <= '0;
               bit_cnt_q <= '0;
            end
         end else begin
            bcd_q     <= bcd_nx;
            sh_q      <= sh_nx;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);

            if (last_bit) begin
               cur_bcd <= bcd_nx;
               done    <= 1'b1;
               if (cap_q > best_bin_q) begin
                  best_bin_q <= cap_q;
                  best_bcd   <= bcd_nx;
                  new_best   <= 1'b1;
               end else begin
                  new_best   <= 1'b0;
               end

               if (ge_rise) begin
                  cap_q       <= score;
                  sh_q        <= score;
                  bcd_q       <= '0;
                  bit_cnt_q   <= '0;
                  pend_full_q <= 1'b0;
                  if (pend_full_q) begin
                     overrun <= 1'b1;
                  end
               end else if (pend_full_q) begin
                  cap_q       <= pend_val_q;
                  sh_q        <= pend_val_q;
                  bcd_q       <= '0;
                  bit_cnt_q   <= '0;
                  pend_full_q <= 1'b0;
               end
            end else if (ge_rise) begin
               pend_val_q  <= score;
               pend_full_q <= 1'b1;
               if (pend_full_q) begin
                  overrun <= 1'b1;
               end
            end
         end

         // Clearing the high score wins over a same-cycle completion.
         if (best_clr) begin
            best_bin_q <= '0;
            best_bcd   <= '0;
            new_best   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_score_bcd_tracker.sv
// Bench for score_bcd_tracker: directed scenarios followed by random game_end/score/best_clr
// traffic, all compared every cycle against an arithmetic reference model.
module tb_score_bcd_tracker;

   localparam int SCORE_W    = 8;
   localparam int BCD_DIGITS = 3;
   localparam int BCD_W      = 4 * BCD_DIGITS;

   logic               clk = 1'b0;
   logic               rst;
   logic [SCORE_W-1:0] score;
   logic               game_end;
   logic               best_clr;
   logic               busy;
   logic               done;
   logic [BCD_W-1:0]   cur_bcd;
   logic [BCD_W-1:0]   best_bcd;
   logic               new_best;
   logic               overrun;

   score_bcd_tracker #(.SCORE_W(SCORE_W), .BCD_DIGITS(BCD_DIGITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .score    (score),
      .game_end (game_end),
      .best_clr (best_clr),
      .busy     (busy),
      .done     (done),
      .cur_bcd  (cur_bcd),
      .best_bcd (best_bcd),
      .new_best (new_best),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int busy_cnt;
   int done_cnt;

   // reference model state: value-level, conversion timed by a cycle countdown
   bit      m_ge_d;
   bit      m_busy;
   int      m_rem;
   int      m_cap;
   bit      m_pend_full;
   int      m_pend;
   int      m_best;
   int      m_cur;
   bit      m_new;
   bit      m_ovr;
   bit      m_done;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         r = r | (32'(x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit rise;
      rise   = game_end && !m_ge_d;
      m_ge_d = game_end;
      m_done = 0;
      if (rst) begin
         m_ge_d = 1; m_busy = 0; m_rem = 0; m_cap = 0; m_pend_full = 0; m_pend = 0;
         m_best = 0; m_cur = 0; m_new = 0; m_ovr = 0;
         return;
      end
      if (!m_busy) begin
         if (rise) begin
            m_busy = 1; m_rem = SCORE_W; m_cap = int'(score);
         end
      end else begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1;
            m_cur  = m_cap;
            if (m_cap > m_best) begin
               m_best = m_cap; m_new = 1;
            end else begin
               m_new = 0;
            end
            if (rise) begin
               if (m_pend_full) m_ovr = 1;
               m_pend_full = 0; m_cap = int'(score); m_rem = SCORE_W;
            end else if (m_pend_full) begin
               m_pend_full = 0; m_cap = m_pend; m_rem = SCORE_W;
            end else begin
               m_busy = 0;
            end
         end else if (rise) begin
            if (m_pend_full) m_ovr = 1;
            m_pend_full = 1; m_pend = int'(score);
         end
      end
      if (best_clr) begin
         m_best = 0; m_new = 0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      check("busy",     32'(busy),     32'(m_busy));
      check("done",     32'(done),     32'(m_done));
      check("cur_bcd",  32'(cur_bcd),  to_bcd(m_cur));
      check("best_bcd", 32'(best_bcd), to_bcd(m_best));
      check("new_best", 32'(new_best), 32'(m_new));
      check("overrun",  32'(overrun),  32'(m_ovr));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // rise at the first edge (E0), game_end dropped at E0+1
   task automatic pulse(input int s);
      score    = SCORE_W'(s);
      game_end = 1'b1;
      cyc();
      game_end = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b1; score = '0; game_end = 1'b0; best_clr = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      run(2);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cur",  32'(cur_bcd), 32'd0);
      rst = 1'b0;
      run(2);

      // 1: first score sets the best; busy for exactly SCORE_W cycles
      busy_cnt = 0;
      pulse(137);
      run(7);
      check("t1_done", 32'(done), 32'd1);
      check("t1_cur",  32'(cur_bcd), 32'h137);
      check("t1_best", 32'(best_bcd), 32'h137);
      check("t1_new",  32'(new_best), 32'd1);
      run(3);
      check("t1_busy_cycles", 32'(busy_cnt), 32'd8);

      // 2: lower score leaves best alone
      pulse(42);
      run(7);
      check("t2_cur",  32'(cur_bcd), 32'h042);
      check("t2_best", 32'(best_bcd), 32'h137);
      check("t2_new",  32'(new_best), 32'd0);
      run(2);

      // 3: max score, then a tie which is not a new best
      pulse(255);
      run(8);
      check("t3_best", 32'(best_bcd), 32'h255);
      check("t3_new",  32'(new_best), 32'd1);
      pulse(255);
      run(8);
      check("t3_tie_new",  32'(new_best), 32'd0);
      check("t3_tie_best", 32'(best_bcd), 32'h255);

      // 4a: second rise 3 clocks later queues into the pending slot
      pulse(10);
      cyc();
      pulse(99);
      run(4);
      check("t4_done1", 32'(done), 32'd1);
      check("t4_cur1",  32'(cur_bcd), 32'h010);
      check("t4_busy_chain", 32'(busy), 32'd1);
      run(8);
      check("t4_done2", 32'(done), 32'd1);
      check("t4_cur2",  32'(cur_bcd), 32'h099);
      check("t4_ovr0",  32'(overrun), 32'd0);
      run(2);

      // 4b: three rises in one conversion -> overrun, latest pending wins
      done_cnt = 0;
      pulse(20);
      pulse(30);
      pulse(40);
      run(20);
      check("t4_ovr1",  32'(overrun), 32'd1);
      check("t4_cur3",  32'(cur_bcd), 32'h040);
      check("t4_dones", 32'(done_cnt), 32'd2);

      // 5: best_clr on the completion cycle
      pulse(77);
      run(6);
      best_clr = 1'b1;
      cyc();
      best_clr = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_cur",  32'(cur_bcd), 32'h077);
      check("t5_best", 32'(best_bcd), 32'h000);
      check("t5_new",  32'(new_best), 32'd0);
      run(2);

      // 6: reset mid-conversion with game_end held across release
      pulse(200);
      run(3);
      rst = 1'b1; game_end = 1'b1;
      cyc();
      rst = 1'b0;
      done_cnt = 0; busy_cnt = 0;
      run(12);
      check("t6_dones", 32'(done_cnt), 32'd0);
      check("t6_busy",  32'(busy_cnt), 32'd0);
      check("t6_cur",   32'(cur_bcd),  32'd0);
      check("t6_ovr",   32'(overrun),  32'd0);
      game_end = 1'b0;
      run(2);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 4) == 0) game_end = ~game_end;
         score    = SCORE_W'($urandom);
         best_clr = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 799) == 0);
         cyc();
      end
      rst = 1'b0; best_clr = 1'b0; game_end = 1'b0;
      run(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
